// File: rtl/lfsr_job_ctrl_if.sv
// Job submit channel for lfsr_job_ctrl: valid/ready handshake plus job parameters.
interface lfsr_job_ctrl_if;
  logic        job_valid;
  logic        job_ready;
  logic [63:0] job_seed;
  logic [63:0] job_poly;
  logic [63:0] job_limit;

  modport master (
    output job_valid, job_seed, job_poly, job_limit,
    input  job_ready
  );

  modport slave (
    input  job_valid, job_seed, job_poly, job_limit,
    output job_ready
  );
endinterface

// File: rtl/lfsr_job_ctrl.sv
// lfsr_job_ctrl: queues LFSR jobs in a 2-deep FIFO and sequences the LFSR
// generator through IDLE -> LOAD -> RUN -> RELEASE for each job.
// Optional watchdog on stalled RUN: define LFSR_CTRL_TIMEOUT_EN.
module lfsr_job_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  lfsr_job_ctrl_if.slave    job,
  input  logic              abort,
  input  logic              ds_ready,
  output logic              lfsr_start,
  output logic              lfsr_pause,
  output logic              lfsr_reset_counter,
  output logic [63:0]       lfsr_seed,
  output logic [63:0]       lfsr_polynomial,
  output logic [63:0]       lfsr_counter_limit,
  input  logic              lfsr_done,
  output logic              busy,
  output logic              job_done,
  output logic              job_aborted,
  output logic [CNT_W-1:0]  job_count,
  output logic              timeout
);

  localparam int unsigned DATA_W = 64;
  localparam int unsigned DEPTH  = 2;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, RELEASE} state_t;

  state_t              state_q, state_d;
  logic                rel_done_q, rel_done_d;
  logic [DATA_W-1:0]   seed_mem  [DEPTH];
  logic [DATA_W-1:0]   poly_mem  [DEPTH];
  logic [DATA_W-1:0]   limit_mem [DEPTH];
  logic                rd_ptr_q, wr_ptr_q;
  logic [1:0]          count_q;
  logic                fifo_full, fifo_empty, push, pop;
  logic                wd_hit;

  assign fifo_full     = (count_q == 2'd2);
  assign fifo_empty    = (count_q == 2'd0);
  assign job.job_ready = !fifo_full;
  assign push          = job.job_valid && !fifo_full;
  assign pop           = (state_q == RELEASE);
  assign busy          = (state_q != IDLE) || !fifo_empty;

  // Head of queue feeds the generator; it cannot move until the RELEASE pop.
  assign lfsr_seed          = fifo_empty ? '0 : seed_mem[rd_ptr_q];
  assign lfsr_polynomial    = fifo_empty ? '0 : poly_mem[rd_ptr_q];
  assign lfsr_counter_limit = fifo_empty ? '0 : limit_mem[rd_ptr_q];

  // FIFO payload storage (no reset needed, masked by fifo_empty).
  always_ff @(posedge clk) begin
    if (push) begin
      seed_mem[wr_ptr_q]  <= job.job_seed;
      poly_mem[wr_ptr_q]  <= job.job_poly;
      limit_mem[wr_ptr_q] <= job.job_limit;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) wr_ptr_q <= !wr_ptr_q;
      if (pop)  rd_ptr_q <= !rd_ptr_q;
      count_q <= count_q + 2'(push) - 2'(pop);
    end
  end

  // FSM state and completion-status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rel_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rel_done_q <= rel_done_d;
    end
  end

  // Next-state and generator control decode.
  always_comb begin
    state_d            = state_q;
    rel_done_d         = rel_done_q;
    lfsr_start         = 1'b0;
    lfsr_pause         = 1'b0;
    lfsr_reset_counter = 1'b0;
    job_done           = 1'b0;
    job_aborted        = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) state_d = LOAD;
      end
      LOAD: begin
        lfsr_start = 1'b1;
        state_d    = RUN;
      end
      RUN: begin
        lfsr_pause = !ds_ready;
        // Completion wins over a simultaneous abort or watchdog expiry.
        if (lfsr_done) begin
          state_d    = RELEASE;
          rel_done_d = 1'b1;
        end else if (abort || wd_hit) begin
          state_d    = RELEASE;
          rel_done_d = 1'b0;
        end
      end
      RELEASE: begin
        lfsr_reset_counter = 1'b1;
        job_done           = rel_done_q;
        job_aborted        = !rel_done_q;
        state_d            = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Completed-job counter, wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) job_count <= '0;
    else if (job_done) job_count <= job_count + CNT_W'(1);
  end

`ifdef LFSR_CTRL_TIMEOUT_EN
  localparam int unsigned WD_W = 16;

  logic [WD_W-1:0] wd_q;
  logic            rel_to_q;
  logic            paused;

  assign paused  = (state_q == RUN) && !ds_ready;
  // Fires in the paused cycle that brings the count to its maximum.
  assign wd_hit  = paused && (wd_q == WD_W'(16'hFFFE));
  assign timeout = (state_q == RELEASE) && rel_to_q;

  // Consecutive-pause watchdog and the timeout flag latched on leaving RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q     <= '0;
      rel_to_q <= 1'b0;
    end else begin
      wd_q <= paused ? wd_q + WD_W'(1) : '0;
      if (state_q == RUN) rel_to_q <= wd_hit && !lfsr_done;
    end
  end
`else
  assign wd_hit  = 1'b0;
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_job_ctrl.sv
// Scoreboard bench for lfsr_job_ctrl: stimulus queues expected completions,
// a monitor checks each job_done/job_aborted pulse against the queue head.
module tb_lfsr_job_ctrl;
  localparam int unsigned CNT_W = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              abort, ds_ready, lfsr_done;
  logic              lfsr_start, lfsr_pause, lfsr_reset_counter;
  logic [63:0]       lfsr_seed, lfsr_polynomial, lfsr_counter_limit;
  logic              busy, job_done, job_aborted, timeout;
  logic [CNT_W-1:0]  job_count;

  lfsr_job_ctrl_if jif ();

  lfsr_job_ctrl #(.CNT_W(CNT_W)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .job                (jif),
    .abort              (abort),
    .ds_ready           (ds_ready),
    .lfsr_start         (lfsr_start),
    .lfsr_pause         (lfsr_pause),
    .lfsr_reset_counter (lfsr_reset_counter),
    .lfsr_seed          (lfsr_seed),
    .lfsr_polynomial    (lfsr_polynomial),
    .lfsr_counter_limit (lfsr_counter_limit),
    .lfsr_done          (lfsr_done),
    .busy               (busy),
    .job_done           (job_done),
    .job_aborted        (job_aborted),
    .job_count          (job_count),
    .timeout            (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]       kind;   // {done, aborted}
    logic [63:0]      seed;
    logic [CNT_W-1:0] cnt;    // job_count seen during the RELEASE cycle
    logic             to;
  } exp_t;

  exp_t             sb[$];
  int               n_vec = 0;
  int               n_err = 0;
  int               n_pop = 0;
  logic [CNT_W-1:0] exp_count = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_done(input logic [63:0] seed);
    sb.push_back('{2'b10, seed, exp_count, 1'b0});
    exp_count = exp_count + CNT_W'(1);
  endtask

  task automatic expect_abort(input logic [63:0] seed, input logic to);
    sb.push_back('{2'b01, seed, exp_count, to});
  endtask

  // Monitor: compare every completion pulse against the scoreboard head.
  always @(posedge clk) begin
    #1;
    if (job_done || job_aborted) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_completion: done=%0b aborted=%0b, expected none (t=%0t)",
                 job_done, job_aborted, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        n_pop++;
        chk("completion_kind", 64'({job_done, job_aborted}), 64'(e.kind));
        chk("completion_seed", lfsr_seed, e.seed);
        chk("completion_count", 64'(job_count), 64'(e.cnt));
        chk("completion_timeout", 64'(timeout), 64'(e.to));
      end
    end
  end

  task automatic push_job(input logic [63:0] seed, input logic [63:0] poly,
                          input logic [63:0] limit, output int waited, output int pops_at);
    @(negedge clk);
    jif.job_valid = 1'b1;
    jif.job_seed  = seed;
    jif.job_poly  = poly;
    jif.job_limit = limit;
    waited = 0;
    while (!jif.job_ready && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 500) begin
      n_vec++;
      n_err++;
      $display("FAIL push_wait: job_ready stayed 0, expected 1 within 500 cycles");
    end
    pops_at = n_pop;
    @(negedge clk);
    jif.job_valid = 1'b0;
  endtask

  task automatic wait_start();
    int n = 0;
    @(negedge clk);
    while (!lfsr_start && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_start: lfsr_start stayed 0, expected 1 within 100 cycles");
    end
  endtask

  // Generator model: finish the job a fixed number of cycles after LOAD.
  task automatic complete_job(input int n_cycles);
    wait_start();
    repeat (n_cycles) @(negedge clk);
    lfsr_done = 1'b1;
    @(negedge clk);
    lfsr_done = 1'b0;
  endtask

  initial begin
    #3000000;
    $display("FAIL global_timeout: simulation still running, expected $finish");
    $fatal(1);
  end

  initial begin
    int w, pa, p, n;
    rst_n = 1'b0;
    abort = 1'b0;
    ds_ready = 1'b1;
    lfsr_done = 1'b0;
    jif.job_valid = 1'b0;
    jif.job_seed  = '0;
    jif.job_poly  = '0;
    jif.job_limit = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_job_ready", 64'(jif.job_ready), 64'(1));
    chk("reset_start", 64'(lfsr_start), 64'(0));
    chk("reset_count", 64'(job_count), 64'(0));
    chk("reset_seed", lfsr_seed, 64'(0));
    chk("reset_timeout", 64'(timeout), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Single job: latency, parameter routing and release pulse.
    expect_done(64'h1);
    push_job(64'h1, 64'hD800_0000_0000_0000, 64'd10, w, pa);
    #1;
    chk("latency_not_early", 64'(lfsr_start), 64'(0));
    chk("busy_pending", 64'(busy), 64'(1));
    chk("head_seed", lfsr_seed, 64'h1);
    chk("head_poly", lfsr_polynomial, 64'hD800_0000_0000_0000);
    chk("head_limit", lfsr_counter_limit, 64'd10);
    @(negedge clk); #1;
    chk("latency_start_t2", 64'(lfsr_start), 64'(1));
    @(negedge clk); #1;
    chk("start_one_cycle", 64'(lfsr_start), 64'(0));
    chk("no_reset_cnt_in_run", 64'(lfsr_reset_counter), 64'(0));
    lfsr_done = 1'b1;
    @(negedge clk);
    lfsr_done = 1'b0;
    #1;
    chk("release_reset_cnt", 64'(lfsr_reset_counter), 64'(1));
    @(negedge clk); #1;
    chk("reset_cnt_one_cycle", 64'(lfsr_reset_counter), 64'(0));
    chk("count_after_first", 64'(job_count), 64'(1));
    chk("idle_not_busy", 64'(busy), 64'(0));

    // Three jobs back-to-back: third waits for the first RELEASE pop.
    expect_done(64'hA);
    expect_done(64'hB);
    expect_done(64'hC);
    push_job(64'hA, 64'h3, 64'd4, w, pa);
    push_job(64'hB, 64'h5, 64'd4, w, pa);
    #1;
    chk("ready_low_when_full", 64'(jif.job_ready), 64'(0));
    n = n_pop;
    fork
      begin
        push_job(64'hC, 64'h7, 64'd4, w, pa);
        chk("third_push_blocked", 64'(w > 0), 64'(1));
        chk("third_after_release", 64'(pa - n), 64'(1));
      end
      begin
        lfsr_done = 1'b1;
        @(negedge clk);
        lfsr_done = 1'b0;
        complete_job(2);
        complete_job(3);
      end
    join

    // ds_ready back-pressure: pause only inside RUN, exactly while low.
    ds_ready = 1'b0;
    #1;
    chk("pause_idle", 64'(lfsr_pause), 64'(0));
    ds_ready = 1'b1;
    expect_done(64'hD);
    push_job(64'hD, 64'h9, 64'd8, w, pa);
    wait_start();
    p = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      ds_ready = 1'b0;
      #1;
      if (lfsr_pause) p++;
    end
    chk("timeout_tied_low", 64'(timeout), 64'(0));
    @(negedge clk);
    ds_ready = 1'b1;
    #1;
    chk("pause_released", 64'(lfsr_pause), 64'(0));
    chk("pause_cycles", 64'(p), 64'(5));
    lfsr_done = 1'b1;
    @(negedge clk);
    lfsr_done = 1'b0;

    // abort with lfsr_done reports done; abort outside RUN is ignored.
    expect_done(64'hE1);
    push_job(64'hE1, 64'h11, 64'd5, w, pa);
    wait_start();
    @(negedge clk);
    abort = 1'b1;
    lfsr_done = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    lfsr_done = 1'b0;
    expect_abort(64'hE2, 1'b0);
    push_job(64'hE2, 64'h13, 64'd5, w, pa);
    wait_start();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    repeat (2) @(negedge clk);
    chk("count_after_abort", 64'(job_count), 64'(exp_count));
    abort = 1'b1;
    repeat (3) @(negedge clk);
    abort = 1'b0;
    chk("abort_idle_not_busy", 64'(busy), 64'(0));

    // Asynchronous reset mid-RUN discards the job silently.
    push_job(64'hF0, 64'h15, 64'd50, w, pa);
    wait_start();
    @(negedge clk);
    ds_ready = 1'b0;
    #1;
    chk("pause_before_reset", 64'(lfsr_pause), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_pause", 64'(lfsr_pause), 64'(0));
    chk("async_rst_busy", 64'(busy), 64'(0));
    chk("async_rst_seed", lfsr_seed, 64'(0));
    chk("async_rst_count", 64'(job_count), 64'(0));
    chk("async_rst_ready", 64'(jif.job_ready), 64'(1));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ds_ready = 1'b1;
    exp_count = '0;
    expect_done(64'hF1);
    push_job(64'hF1, 64'h17, 64'd3, w, pa);
    complete_job(1);

`ifdef LFSR_CTRL_TIMEOUT_EN
    // Watchdog: abort with timeout after the maximum run of paused cycles.
    expect_abort(64'h7E, 1'b1);
    push_job(64'h7E, 64'h19, 64'd100, w, pa);
    wait_start();
    ds_ready = 1'b0;
    p = 0;
    n = 0;
    while (n < 70000) begin
      @(negedge clk);
      #1;
      if (job_aborted) break;
      if (lfsr_pause) p++;
      n++;
    end
    ds_ready = 1'b1;
    chk("watchdog_paused_cycles", 64'(p), 64'(65535));
`endif

    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drained", 64'(sb.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/lfsr_job_ctrl.md
LFSR_JOB_CTRL -- requirements
Module: lfsr_job_ctrl

Interface
REQ-001 SHALL provide parameter CNT_W, default 16, width of the completed-job counter.
REQ-002 SHALL provide ports: clk  in  1  clock, rising edge; rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL provide ports: job_valid in 1, job_ready out 1 (job submit handshake); job_seed, job_poly, job_limit  in  64 each (job parameters).
REQ-004 SHALL provide ports: abort  in  1  (cancel the running job); ds_ready  in  1  (downstream cipher unit can accept a message).
REQ-005 SHALL provide ports: lfsr_start, lfsr_pause, lfsr_reset_counter  out  1 each; lfsr_seed, lfsr_polynomial, lfsr_counter_limit  out  64 each; lfsr_done  in  1 (LFSR generator control and status).
REQ-006 SHALL provide ports: busy out 1; job_done out 1 (pulse); job_aborted out 1 (pulse); job_count out CNT_W; timeout out 1 (pulse).

Function
REQ-007 SHALL hold jobs in a 2-entry FIFO of {seed, poly, limit}; job_ready = not full; push on job_valid && job_ready.
REQ-008 SHALL drive lfsr_seed, lfsr_polynomial and lfsr_counter_limit from the FIFO head, or 0 when the FIFO is empty, and hold them stable from IDLE through RELEASE.
REQ-009 SHALL implement FSM states IDLE, LOAD, RUN, RELEASE.
REQ-010 IDLE: FIFO non-empty -> LOAD next cycle; otherwise stay.
REQ-011 LOAD: lfsr_start = 1 for exactly this one cycle; -> RUN.
REQ-012 RUN: lfsr_pause = !ds_ready (combinational, RUN only); lfsr_done -> RELEASE with done status; else abort -> RELEASE with aborted status.
REQ-013 RELEASE: lfsr_reset_counter = 1 for this one cycle; pop FIFO head; job_done or job_aborted pulses for this one cycle; -> IDLE.
REQ-014 SHALL let lfsr_done take priority over an abort in the same cycle, so the job is reported done.
REQ-015 SHALL ignore abort outside RUN.
REQ-016 SHALL increment job_count by 1 on each job_done, wrapping from 2^CNT_W-1 to 0; aborts do not count.
REQ-017 busy = (state != IDLE) || FIFO non-empty.
REQ-018 Minimum latency: job pushed at edge t -> LOAD (lfsr_start high) during cycle t+2.
REQ-019 SHALL block a push in a cycle where the FIFO is full, even if RELEASE pops in that cycle, because job_ready reflects fullness only.
REQ-020 All lfsr_* control outputs SHALL be 0 outside the states named in REQ-011 to REQ-013.

Reset
REQ-021 On rst_n low, regardless of clk: state = IDLE, FIFO empty, job_count = 0, watchdog = 0, and all outputs 0 (job_ready = 1 once the FIFO is empty).
REQ-022 A reset during RUN SHALL discard the job without a job_done or job_aborted pulse; the LFSR is re-initialised by its own reset.

Configuration
REQ-023 Macro LFSR_CTRL_TIMEOUT_EN defined: a 16-bit watchdog counts consecutive RUN cycles with lfsr_pause = 1 and clears on any other cycle; on reaching 65535 it acts as an abort and pulses timeout together with job_aborted.
REQ-024 Macro LFSR_CTRL_TIMEOUT_EN undefined: no watchdog logic is built and timeout is tied to 0.

Verification
REQ-025 Push one job (seed 0x1, poly 0xD800000000000000, limit 10), ds_ready = 1, LFSR model -> lfsr_start 1 cycle at t+2, lfsr_done -> 1-cycle lfsr_reset_counter and job_done, job_count = 1.
REQ-026 Push 3 jobs back-to-back -> job_ready low after the 2nd, 3rd accepted after the first RELEASE; three job_done pulses in order, with lfsr_seed matching each job.
REQ-027 Deassert ds_ready for 5 cycles during RUN -> lfsr_pause high exactly those 5 cycles; job still completes.
REQ-028 Assert abort together with lfsr_done -> job_done = 1, job_aborted = 0; abort alone in RUN -> job_aborted = 1, job_count unchanged.
REQ-029 Assert rst_n low mid-RUN, asynchronously -> all outputs 0 immediately, FIFO empty, no completion pulse.
REQ-030 With LFSR_CTRL_TIMEOUT_EN defined, hold ds_ready = 0 in RUN -> timeout and job_aborted pulse after 65535 paused cycles; without the macro, timeout stays 0.
